// File: rtl/uart_rx_nibble.sv
// uart_rx_nibble: 8N1 UART receiver that holds the last good byte and splits it into two hex nibbles.
// Framing errors and false starts never disturb the held byte.
module uart_rx_nibble #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [3:0] o_hi,
    output logic [3:0] o_lo,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_ferr,
    output logic       o_busy
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW = $clog2(CPB);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
    state_t state, state_n;
    logic [1:0] sync;
    logic rxs;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] sh, sh_n, data_n;
    logic valid_n, ferr_n;
    assign rxs = sync[1];
    assign o_hi = o_data[7:4];
    assign o_lo = o_data[3:0];
    assign o_busy = state != IDLE;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync <= 2'b11;
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            sh <= '0;
            o_data <= '0;
            o_valid <= 1'b0;
            o_ferr <= 1'b0;
        end else begin
            sync <= {sync[0], i_rx};
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            sh <= sh_n;
            o_data <= data_n;
            o_valid <= valid_n;
            o_ferr <= ferr_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt + 1'b1;
        idx_n = idx;
        sh_n = sh;
        data_n = o_data;
        valid_n = 1'b0;
        ferr_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = START;
            end
            START: if (cnt == HALF) begin
                cnt_n = '0;
                idx_n = '0;
                state_n = rxs ? IDLE : DATA;
            end
            DATA: if (cnt == LAST) begin
                cnt_n = '0;
                sh_n[idx] = rxs;
                idx_n = idx + 3'd1;
                if (idx == 3'd7) state_n = STOP;
            end
            STOP: if (cnt == LAST) begin
                cnt_n = '0;
                state_n = rxs ? IDLE : WAIT_HI;
                valid_n = rxs;
                ferr_n = !rxs;
                data_n = rxs ? sh : o_data;
            end
            WAIT_HI: begin
                cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_nibble.sv
// tb_uart_rx_nibble: scoreboard bench; a sample-point model of the line predicts every
// o_valid/o_ferr pulse (time and byte) and every o_busy interval length.
module tb_uart_rx_nibble;
    localparam int CPB = 10;
    localparam int H = CPB / 2;
    logic i_clk = 1'b0, i_rst = 1'b1, i_rx = 1'b1;
    logic [3:0] o_hi, o_lo;
    logic [7:0] o_data;
    logic o_valid, o_ferr, o_busy;
    uart_rx_nibble #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx(i_rx), .o_hi(o_hi), .o_lo(o_lo),
        .o_data(o_data), .o_valid(o_valid), .o_ferr(o_ferr), .o_busy(o_busy)
    );
    always #5 i_clk = ~i_clk;
    typedef struct {bit ferr; logic [7:0] d; int at;} ev_t;
    ev_t evq[$];
    int busyq[$];
    bit w[$];
    int cyc = 0, nvec = 0, nerr = 0, blen = 0;
    bit bprev = 1'b0;
    logic [7:0] last_good = 8'h00;
    ev_t e;
    always @(posedge i_clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask
    function automatic void add_bits(input bit v, input int n);
        repeat (n) w.push_back(v);
    endfunction
    function automatic void add_frame(input logic [7:0] b, input int p = CPB, input bit stop = 1'b1);
        add_bits(1'b0, p);
        for (int k = 0; k < 8; k++) add_bits(b[k], p);
        add_bits(stop, p);
    endfunction
    // Line index i is the value presented before relative edge i+1; the receiver sees it 3 edges later.
    // Expectations come from sampling the line at the nominal points, not from the byte that was sent.
    function automatic void predict(input int base);
        int p = 0, f, h;
        logic [7:0] d;
        while (1) begin
            f = p;
            while (f < w.size() && w[f]) f++;
            if (f + H + 9 * CPB >= w.size()) break;
            if (w[f + H]) begin
                busyq.push_back(H);
                p = f + H + 1;
                continue;
            end
            for (int k = 0; k < 8; k++) d[k] = w[f + H + CPB * (k + 1)];
            if (w[f + H + 9 * CPB]) begin
                evq.push_back(ev_t'{1'b0, d, base + f + H + 9 * CPB + 3});
                busyq.push_back(H + 9 * CPB);
                p = f + H + 9 * CPB + 1;
            end else begin
                evq.push_back(ev_t'{1'b1, d, base + f + H + 9 * CPB + 3});
                h = f + H + 9 * CPB + 1;
                while (h < w.size() && !w[h]) h++;
                busyq.push_back(h - f);
                p = h + 1;
            end
        end
    endfunction
    task automatic drive();
        @(negedge i_clk);
        predict(cyc);
        for (int i = 0; i < w.size(); i++) begin
            if (i > 0) @(negedge i_clk);
            i_rx = w[i];
        end
        w.delete();
    endtask
    always @(negedge i_clk) begin
        if (i_rst) last_good = 8'h00;
        else if (o_valid || o_ferr) begin
            if (evq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_pulse: got valid=%0b ferr=%0b, expected none", o_valid, o_ferr);
            end else begin
                e = evq.pop_front();
                chk("overlap", o_valid && o_ferr, 0);
                chk("pulse_kind_ferr", o_ferr, e.ferr);
                chk("pulse_cycle", cyc, e.at);
                if (!e.ferr) begin
                    chk("o_data", o_data, e.d);
                    chk("o_hi", o_hi, e.d[7:4]);
                    chk("o_lo", o_lo, e.d[3:0]);
                    last_good = e.d;
                end else chk("ferr_data_hold", o_data, last_good);
            end
        end
    end
    always @(negedge i_clk) begin
        if (i_rst) begin
            blen = 0;
            bprev = 1'b0;
        end else begin
            if (o_busy) blen++;
            else if (bprev) begin
                if (busyq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_busy: got interval of %0d, expected none", blen);
                end else chk("busy_len", blen, busyq.pop_front());
                blen = 0;
            end
            bprev = o_busy;
        end
    end
    initial begin
        logic [7:0] b;
        int per;
        bit st;
        repeat (2) @(negedge i_clk);
        chk("rst_data", o_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_ferr", o_ferr, 0);
        #1 i_rst = 1'b0;
        add_bits(1'b1, 5); add_bits(1'b0, 3); add_bits(1'b1, 200); drive();
        chk("false_start_hi", o_hi, 0);
        chk("false_start_lo", o_lo, 0);
        add_bits(1'b1, 4); add_frame(8'hA5); add_bits(1'b1, 20); drive();
        add_frame(8'h12); add_bits(1'b1, 7); add_frame(8'h3C, CPB, 1'b0);
        add_bits(1'b0, 50); add_bits(1'b1, 20); drive();
        chk("ferr_hold_hi", o_hi, 4'h1);
        chk("ferr_hold_lo", o_lo, 4'h2);
        add_frame(8'h7E); add_bits(1'b1, 15); drive();
        add_bits(1'b1, 3); add_frame(8'hC3);
        for (int i = 0; i < 59; i++) begin
            @(negedge i_clk);
            i_rx = w[i];
        end
        w.delete();
        chk("pre_rst_busy", o_busy, 1);
        #1 i_rst = 1'b1;
        #1;
        chk("mid_rst_data", o_data, 0);
        chk("mid_rst_hi", o_hi, 0);
        chk("mid_rst_lo", o_lo, 0);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_ferr", o_ferr, 0);
        chk("mid_rst_busy", o_busy, 0);
        i_rx = 1'b1;
        repeat (3) @(negedge i_clk);
        #1 i_rst = 1'b0;
        add_bits(1'b1, 10); add_frame(8'h5A); add_bits(1'b1, 20); drive();
        add_frame(8'h00); add_frame(8'hFF); add_bits(1'b1, 15); drive();
        chk("b2b_hi", o_hi, 4'hF);
        chk("b2b_lo", o_lo, 4'hF);
        add_frame(8'h96, 11); add_bits(1'b1, 20); add_frame(8'h96, 9); add_bits(1'b1, 20); drive();
        repeat (30) begin
            b = 8'($urandom);
            per = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 11)) : CPB;
            st = $urandom_range(0, 5) != 0;
            if ($urandom_range(0, 5) == 0) begin
                add_bits(1'b0, $urandom_range(1, 4));
                add_bits(1'b1, $urandom_range(6, 10));
            end
            add_frame(b, per, st);
            if (!st) add_bits(1'b0, $urandom_range(0, 30));
            add_bits(1'b1, $urandom_range(0, 12));
        end
        add_bits(1'b1, 120); drive();
        repeat (5) @(negedge i_clk);
        chk("pending_pulses", evq.size(), 0);
        chk("pending_busy", busyq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
